// File: rtl/inst_decode_buffer.sv
// Instruction FIFO between fetch and decode; presents the head word with its fields pre-split plus the extender sign control.
// Latency: a word accepted at edge N is visible on id_* after edge N (no bypass); head outputs are combinational from storage.
// Backpressure: if_ready is low when full or in reset, derived from registered state only; a stalled decode never loses a word.
module inst_decode_buffer #(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [PC_WIDTH-1:0] if_pc,
    input  logic [31:0]         if_inst,
    input  logic                if_exc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [31:0]         id_inst,
    output logic                id_exc,
    output logic [5:0]          id_opcode,
    output logic [4:0]          id_rs,
    output logic [4:0]          id_rt,
    output logic [4:0]          id_rd,
    output logic [4:0]          id_sa,
    output logic [5:0]          id_funct,
    output logic [15:0]         id_imm16,
    output logic                id_ex_sign
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [5:0]    OP_ANDI  = 6'h0C;
    localparam logic [5:0]    OP_ORI   = 6'h0D;
    localparam logic [5:0]    OP_XORI  = 6'h0E;

    // Storage: data is never cleared; only pointers and count are reset.
    logic [PC_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [31:0]         r_inst_mem [DEPTH];
    logic                r_exc_mem  [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    logic [PC_WIDTH-1:0] w_head_pc;
    logic [31:0]         w_head_inst;
    logic                w_head_exc;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Handshake: ready depends only on state and reset, never on id_ready.
    assign if_ready = !w_full && !rst;
    assign id_valid = !w_empty && !rst;

    // A flush cycle cancels both sides; the offered word is intentionally dropped.
    assign w_push = if_valid && if_ready && !flush;
    assign w_pop  = id_valid && id_ready && !flush;

    // Pointer and occupancy bookkeeping; reset outranks flush, both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry write: PC, word and exception flag travel together untouched.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= if_pc;
            r_inst_mem[r_wr_ptr] <= if_inst;
            r_exc_mem[r_wr_ptr]  <= if_exc;
        end
    end

    assign w_head_pc   = r_pc_mem[r_rd_ptr];
    assign w_head_inst = r_inst_mem[r_rd_ptr];
    assign w_head_exc  = r_exc_mem[r_rd_ptr];

    // Head presentation: gated to zero (a nop) whenever nothing valid is held, hiding stale storage.
    always_comb begin
        id_pc   = '0;
        id_inst = '0;
        id_exc  = 1'b0;
        if (id_valid) begin
            id_pc   = w_head_pc;
            id_inst = w_head_inst;
            id_exc  = w_head_exc;
        end
    end

    assign id_opcode = id_inst[31:26];
    assign id_rs     = id_inst[25:21];
    assign id_rt     = id_inst[20:16];
    assign id_rd     = id_inst[15:11];
    assign id_sa     = id_inst[10:6];
    assign id_funct  = id_inst[5:0];
    assign id_imm16  = id_inst[15:0];

    // Extender control: only the logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        id_ex_sign = 1'b0;
        if (id_valid) begin
            id_ex_sign = !((id_opcode == OP_ANDI) || (id_opcode == OP_ORI) || (id_opcode == OP_XORI));
        end
    end

endmodule

// File: tb/tb_inst_decode_buffer.sv
// Bench for inst_decode_buffer: directed steps followed by a randomized phase against a queue model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// The model holds entries in a plain queue and derives every expected output from it.
module tb_inst_decode_buffer;

    localparam int DEPTH = 2;
    localparam int PCW   = 32;

    typedef struct {
        logic [PCW-1:0] pc;
        logic [31:0]    inst;
        logic           exc;
    } entry_t;

    logic           clk = 1'b0;
    logic           rst, flush, if_valid, if_ready, if_exc, id_valid, id_ready, id_exc, id_ex_sign;
    logic [PCW-1:0] if_pc, id_pc;
    logic [31:0]    if_inst, id_inst;
    logic [5:0]     id_opcode, id_funct;
    logic [4:0]     id_rs, id_rt, id_rd, id_sa;
    logic [15:0]    id_imm16;

    int checks   = 0;
    int failures = 0;
    entry_t q[$];

    inst_decode_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst), .if_exc(if_exc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst), .id_exc(id_exc),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_sa(id_sa),
        .id_funct(id_funct), .id_imm16(id_imm16), .id_ex_sign(id_ex_sign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, then advance the model across one edge.
    task automatic tick();
        entry_t         h;
        logic           m_rdy, m_vld, do_push, do_pop;
        logic [31:0]    e_inst;
        logic           e_sign;
        @(negedge clk);
        m_rdy = (q.size() < DEPTH) && !rst;
        m_vld = (q.size() != 0) && !rst;
        h.pc = '0; h.inst = '0; h.exc = 1'b0;
        if (m_vld) h = q[0];
        e_inst = h.inst;
        e_sign = m_vld && !(e_inst[31:26] inside {6'h0C, 6'h0D, 6'h0E});
        chk("if_ready", 64'(if_ready), 64'(m_rdy));
        chk("id_valid", 64'(id_valid), 64'(m_vld));
        chk("id_pc", 64'(id_pc), 64'(h.pc));
        chk("id_inst", 64'(id_inst), 64'(e_inst));
        chk("id_exc", 64'(id_exc), 64'(h.exc));
        chk("fields", {id_opcode, id_rs, id_rt, id_rd, id_sa, id_funct, id_imm16},
            {e_inst[31:26], e_inst[25:21], e_inst[20:16], e_inst[15:11], e_inst[10:6], e_inst[5:0], e_inst[15:0]});
        chk("id_ex_sign", 64'(id_ex_sign), 64'(e_sign));
        do_push = if_valid && m_rdy && !flush;
        do_pop  = m_vld && id_ready && !flush;
        h.pc = if_pc; h.inst = if_inst; h.exc = if_exc;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(h);
        end
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic exc);
        if_valid = 1'b1; if_pc = pc; if_inst = inst; if_exc = exc;
    endtask

    initial begin
        logic [31:0] base;
        logic [5:0]  ops [4];
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = '0; if_inst = '0; if_exc = 1'b0;
        ops[0] = 6'h0C; ops[1] = 6'h0D; ops[2] = 6'h0E; ops[3] = 6'h08;

        // 1: reset, then a single addiu push
        tick(); tick();
        chk("rst_id_inst", 64'(id_inst), 64'h0);
        rst = 1'b0; #1;
        chk("post_rst_ready", 64'(if_ready), 64'h1);
        offer(32'hBFC00000, 32'h24080005, 1'b0);
        tick();
        if_valid = 1'b0; #1;
        chk("t1_valid", 64'(id_valid), 64'h1);
        chk("t1_rt", 64'(id_rt), 64'h8);
        chk("t1_imm", 64'(id_imm16), 64'h0005);
        chk("t1_sign", 64'(id_ex_sign), 64'h1);
        id_ready = 1'b1; tick(); id_ready = 1'b0;

        // 2: fill and backpressure
        offer(32'h100, 32'h3508FFFF, 1'b0); tick();
        offer(32'h104, 32'h2108FFFF, 1'b0); tick();
        chk("t2_full_ready", 64'(if_ready), 64'h0);
        offer(32'h108, 32'h12345678, 1'b0); tick();
        chk("t2_head_ori", 64'(id_inst), 64'h3508FFFF);
        chk("t2_ori_sign", 64'(id_ex_sign), 64'h0);
        if_valid = 1'b0; id_ready = 1'b1; tick();
        chk("t2_head_addi", 64'(id_inst), 64'h2108FFFF);
        chk("t2_addi_sign", 64'(id_ex_sign), 64'h1);
        tick();
        chk("t2_empty", 64'(id_valid), 64'h0);

        // 3: streaming push+pop at occupancy 1
        id_ready = 1'b0; offer(32'h2000, 32'h00000020, 1'b0); tick();
        id_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            offer(32'h2000 + 32'(i * 4), $urandom, 1'b0);
            tick();
            chk("t3_pc_order", 64'(id_pc), 64'(32'h2000 + 32'(i * 4)));
            chk("t3_ready", 64'(if_ready), 64'h1);
        end
        if_valid = 1'b0; tick();

        // 4: flush with two entries, push and pop both requested
        id_ready = 1'b0;
        offer(32'h300, 32'h8C010000, 1'b0); tick();
        offer(32'h304, 32'hAC010004, 1'b0); tick();
        offer(32'h308, 32'h30420001, 1'b0); flush = 1'b1; id_ready = 1'b1; tick();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0; #1;
        chk("t4_valid", 64'(id_valid), 64'h0);
        chk("t4_inst", 64'(id_inst), 64'h0);
        offer(32'h400, 32'h38A5BEEF, 1'b0); tick();
        if_valid = 1'b0; #1;
        chk("t4_next", 64'(id_inst), 64'h38A5BEEF);
        id_ready = 1'b1; tick(); id_ready = 1'b0;

        // 5: exception flag travels with its word
        offer(32'h00000010, 32'h00000000, 1'b0); tick();
        offer(32'h00000003, 32'h00000000, 1'b1); tick();
        chk("t5_first_exc", 64'(id_exc), 64'h0);
        if_valid = 1'b0; id_ready = 1'b1; tick();
        chk("t5_exc", 64'(id_exc), 64'h1);
        chk("t5_pc", 64'(id_pc), 64'h3);
        offer(32'h00000014, 32'h00000000, 1'b0); tick();
        chk("t5_next_exc", 64'(id_exc), 64'h0);
        if_valid = 1'b0; tick();

        // 6: reset mid-stream, then reset together with flush
        id_ready = 1'b0;
        offer(32'h500, 32'h11111111, 1'b0); tick();
        offer(32'h504, 32'h22222222, 1'b0); tick();
        offer(32'h508, 32'h33333333, 1'b0); rst = 1'b1; #1;
        chk("t6_rst_ready", 64'(if_ready), 64'h0);
        chk("t6_rst_valid", 64'(id_valid), 64'h0);
        tick();
        if_valid = 1'b0; rst = 1'b0; #1;
        chk("t6_after_valid", 64'(id_valid), 64'h0);
        chk("t6_after_ready", 64'(if_ready), 64'h1);
        offer(32'h600, 32'h44444444, 1'b0); tick();
        offer(32'h604, 32'h55555555, 1'b0); tick();
        rst = 1'b1; flush = 1'b1; tick();
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0; #1;
        chk("t6_rf_valid", 64'(id_valid), 64'h0);
        chk("t6_rf_ready", 64'(if_ready), 64'h1);

        // Randomized traffic against the queue model
        base = 32'h8000_0000;
        for (int i = 0; i < 400; i++) begin
            if_valid = 1'($urandom_range(0, 3) != 0);
            id_ready = 1'($urandom_range(0, 2) != 0);
            flush    = 1'($urandom_range(0, 19) == 0);
            rst      = 1'($urandom_range(0, 59) == 0);
            if_pc    = base + 32'(i * 4);
            if_inst  = $urandom;
            if ($urandom_range(0, 1) == 1) if_inst[31:26] = ops[$urandom_range(0, 3)];
            if_exc   = 1'($urandom_range(0, 7) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
        tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
